sfp_ctrl: RTL and testbench

Sequencer for the accumulate/ReLU special-function stage. It sits between the partial-sum SRAM, the SFP column array and the output SRAM. For each output pixel it clears the SFP accumulators, then streams `cfg_kij` partial sums (one per kernel position) from psum memory into the SFP. After the last accumulation settles, it commits the ReLU'd result to the output SRAM. Commands use a simple start/done handshake from the top-level core controller.

---
 rtl/sfp_ctrl_pkg.sv | 17 +
 rtl/sfp_ctrl_agen.sv | 53 +++++
 rtl/sfp_ctrl.sv | 133 +++++++++++++
 tb/tb_sfp_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_ctrl_pkg.sv
// Shared types and constants for the accumulate/ReLU sequencer (sfp_ctrl).
package sfp_ctrl_pkg;

    localparam int ADDR_BW_DEF  = 11;
    localparam int KIJ_BW_DEF   = 4;
    localparam int PIX_OVERHEAD = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } sfp_state_t;

endpackage

// File: rtl/sfp_ctrl_agen.sv
// Address generator: running psum base, kernel-position counter k and pixel index o.
module sfp_ctrl_agen
    import sfp_ctrl_pkg::*;
#(
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int kij_bw  = KIJ_BW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               clr_pix,
    input  logic               step,
    input  logic               next_pix,
    input  logic [kij_bw-1:0]  kij,
    input  logic [addr_bw-1:0] onij,
    output logic [addr_bw-1:0] psum_addr,
    output logic [addr_bw-1:0] out_addr,
    output logic               last_k,
    output logic               last_o
);

    logic [addr_bw-1:0] r_base;
    logic [kij_bw-1:0]  r_k;
    logic [addr_bw-1:0] r_o;

    // Stride by onij with an adder; the sum wraps modulo 2^addr_bw by width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base <= '0;
            r_k    <= '0;
            r_o    <= '0;
        end else begin
            if (init)
                r_o <= '0;
            else if (next_pix)
                r_o <= r_o + addr_bw'(1);

            if (clr_pix) begin
                r_k    <= '0;
                r_base <= r_o;
            end else if (step) begin
                r_k    <= r_k + kij_bw'(1);
                r_base <= r_base + onij;
            end
        end
    end

    assign psum_addr = r_base;
    assign out_addr  = r_o;
    assign last_k    = (r_k == kij - kij_bw'(1));
    assign last_o    = (r_o == onij - addr_bw'(1));

endmodule

// File: rtl/sfp_ctrl.sv
// Accumulate/ReLU sequencer: clears SFP, streams cfg_kij psums per pixel, commits output.
// Optional busy-cycle counter perf_cycles enabled by `define SFP_CTRL_PERF_EN.
module sfp_ctrl
    import sfp_ctrl_pkg::*;
#(
    parameter int col     = 8,
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int kij_bw  = KIJ_BW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [kij_bw-1:0]  cfg_kij,
    input  logic [addr_bw-1:0] cfg_onij,
    output logic               psum_ren,
    output logic [addr_bw-1:0] psum_addr,
    output logic [col-1:0]     sfp_valid,
    output logic               acc_clr,
    output logic               out_wen,
    output logic [addr_bw-1:0] out_addr,
    input  logic               out_ready,
    output logic               busy,
`ifdef SFP_CTRL_PERF_EN
    output logic [31:0]        perf_cycles,
`endif
    output logic               done
);

    sfp_state_t         r_state;
    sfp_state_t         w_next;
    logic [kij_bw-1:0]  r_cfg_kij;
    logic [addr_bw-1:0] r_cfg_onij;
    logic               r_vld_p1;
    logic               w_accept;
    logic               w_cfg_ok;
    logic               w_init;
    logic               w_last_k;
    logic               w_last_o;
    logic               w_next_pix;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    assign w_cfg_ok   = (cfg_kij != '0) && (cfg_onij != '0);
    assign w_init     = w_accept && w_cfg_ok;
    assign w_next_pix = (r_state == S_WRITE) && out_ready && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_cfg_ok ? S_CLEAR : S_DONE;
            S_CLEAR: w_next = S_READ;
            S_READ:  if (w_last_k) w_next = S_WAIT;
            S_WAIT:  w_next = S_WRITE;
            S_WRITE: if (out_ready) w_next = w_last_o ? S_DONE : S_CLEAR;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE))
            w_next = S_IDLE;
    end

    always_comb begin
        psum_ren = (r_state == S_READ);
        acc_clr  = (r_state == S_CLEAR);
        out_wen  = (r_state == S_WRITE);
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_kij  <= '0;
            r_cfg_onij <= '0;
        end else if (w_init) begin
            r_cfg_kij  <= cfg_kij;
            r_cfg_onij <= cfg_onij;
        end
    end

    // Stage p1: psum read data lands one cycle after the enable; the SFP strobe follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= psum_ren;
        end
    end

    assign sfp_valid = {col{r_vld_p1}};

    sfp_ctrl_agen #(
        .addr_bw (addr_bw),
        .kij_bw  (kij_bw)
    ) u_agen (
        .clk       (clk),
        .reset     (reset),
        .init      (w_init),
        .clr_pix   (r_state == S_CLEAR),
        .step      (r_state == S_READ),
        .next_pix  (w_next_pix),
        .kij       (r_cfg_kij),
        .onij      (r_cfg_onij),
        .psum_addr (psum_addr),
        .out_addr  (out_addr),
        .last_k    (w_last_k),
        .last_o    (w_last_o)
    );

`ifdef SFP_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (busy && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed scoreboard bench for sfp_ctrl; covers perf_cycles when SFP_CTRL_PERF_EN is defined.
module tb_sfp_ctrl;
    import sfp_ctrl_pkg::*;

    localparam int COL = 8;
    localparam int ABW = 11;
    localparam int KBW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [KBW-1:0] cfg_kij;
    logic [ABW-1:0] cfg_onij;
    logic           psum_ren;
    logic [ABW-1:0] psum_addr;
    logic [COL-1:0] sfp_valid;
    logic           acc_clr;
    logic           out_wen;
    logic [ABW-1:0] out_addr;
    logic           out_ready;
    logic           busy;
    logic           done;
`ifdef SFP_CTRL_PERF_EN
    logic [31:0]    perf_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    logic [ABW-1:0] q_psum[$];
    logic [ABW-1:0] q_out[$];

    int n_done, done_cyc, n_vld, n_ren, n_wen, n_clr;
    int first_clr, first_ren, first_wen;
    logic busy_after_abort, vld_after_abort;

    always #5 clk = ~clk;

    sfp_ctrl #(
        .col     (COL),
        .addr_bw (ABW),
        .kij_bw  (KBW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_kij     (cfg_kij),
        .cfg_onij    (cfg_onij),
        .psum_ren    (psum_ren),
        .psum_addr   (psum_addr),
        .sfp_valid   (sfp_valid),
        .acc_clr     (acc_clr),
        .out_wen     (out_wen),
        .out_addr    (out_addr),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef SFP_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command at edge 0 and watch cycles 1..end; abort_at=0 means no abort.
    task automatic run(input int kij, input int onij, input int stall_n,
                       input int abort_at, input int max_reads);
        int cyc, stall_left, nreads, end_cyc;
        q_psum.delete();
        q_out.delete();
        nreads = 0;
        if (kij > 0 && onij > 0) begin
            for (int o = 0; o < onij; o++) begin
                q_out.push_back(ABW'(o));
                for (int k = 0; k < kij; k++) begin
                    if (nreads < max_reads) begin
                        q_psum.push_back(ABW'(o + k * onij));
                        nreads++;
                    end
                end
            end
        end
        n_done = 0; done_cyc = 0; n_vld = 0; n_ren = 0; n_wen = 0; n_clr = 0;
        first_clr = 0; first_ren = 0; first_wen = 0;
        busy_after_abort = 1'bx; vld_after_abort = 1'bx;
        end_cyc = (abort_at > 0) ? abort_at + 4 : 1 + onij * (kij + PIX_OVERHEAD) + stall_n + 4;

        cfg_kij   = KBW'(kij);
        cfg_onij  = ABW'(onij);
        start     = 1'b1;
        abort     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        cyc        = 1;
        stall_left = stall_n;
        while (cyc <= end_cyc) begin
            abort = (cyc == abort_at);
            if (out_wen && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (acc_clr) begin
                n_clr++;
                if (first_clr == 0) first_clr = cyc;
            end
            if (psum_ren) begin
                n_ren++;
                if (first_ren == 0) first_ren = cyc;
                chk("psum_q_nonempty", 64'(q_psum.size() > 0), 64'd1);
                if (q_psum.size() > 0) chk("psum_addr", 64'(psum_addr), 64'(q_psum.pop_front()));
            end
            if (sfp_valid != '0) begin
                n_vld++;
                chk("sfp_valid_all_cols", 64'(sfp_valid), 64'({COL{1'b1}}));
            end
            if (out_wen) begin
                n_wen++;
                if (first_wen == 0) first_wen = cyc;
                if (out_ready) begin
                    chk("out_q_nonempty", 64'(q_out.size() > 0), 64'd1);
                    if (q_out.size() > 0) chk("out_addr", 64'(out_addr), 64'(q_out.pop_front()));
                end
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (abort_at > 0 && cyc == abort_at + 1) begin
                busy_after_abort = busy;
                vld_after_abort  = sfp_valid[0];
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        abort     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        cfg_kij = KBW'(2); cfg_onij = ABW'(2);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psum_ren", 64'(psum_ren), 64'd0);
        chk("rst_acc_clr", 64'(acc_clr), 64'd0);
        chk("rst_out_wen", 64'(out_wen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sfp_valid", 64'(sfp_valid), 64'd0);
        chk("rst_psum_addr", 64'(psum_addr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
`ifdef SFP_CTRL_PERF_EN
        chk("rst_perf", 64'(perf_cycles), 64'd0);
`endif
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // kij=9, onij=4, out_ready tied high
        run(9, 4, 0, 0, 1000);
        chk("k9o4_done_cycle", 64'(done_cyc), 64'd49);
        chk("k9o4_done_count", 64'(n_done), 64'd1);
        chk("k9o4_ren_count", 64'(n_ren), 64'd36);
        chk("k9o4_vld_count", 64'(n_vld), 64'd36);
        chk("k9o4_clr_count", 64'(n_clr), 64'd4);
        chk("k9o4_wen_count", 64'(n_wen), 64'd4);
        chk("k9o4_psum_left", 64'(q_psum.size()), 64'd0);
        chk("k9o4_out_left", 64'(q_out.size()), 64'd0);
`ifdef SFP_CTRL_PERF_EN
        chk("k9o4_perf", 64'(perf_cycles), 64'd49);
        repeat (5) @(posedge clk);
        #1;
        chk("k9o4_perf_idle", 64'(perf_cycles), 64'd49);
`endif

        // kij=1, onij=1 state timeline
        run(1, 1, 0, 0, 1000);
        chk("k1o1_clear_cycle", 64'(first_clr), 64'd1);
        chk("k1o1_read_cycle", 64'(first_ren), 64'd2);
        chk("k1o1_ren_count", 64'(n_ren), 64'd1);
        chk("k1o1_write_cycle", 64'(first_wen), 64'd4);
        chk("k1o1_done_cycle", 64'(done_cyc), 64'd5);

        // kij=3, onij=2, out_ready low for 2 cycles at the first WRITE
        run(3, 2, 2, 0, 1000);
        chk("k3o2_wen_cycles", 64'(n_wen), 64'd4);
        chk("k3o2_done_cycle", 64'(done_cyc), 64'd15);
        chk("k3o2_psum_left", 64'(q_psum.size()), 64'd0);
        chk("k3o2_out_left", 64'(q_out.size()), 64'd0);

        // abort during the second READ of kij=9, onij=4
        run(9, 4, 0, 3, 2);
        chk("abort_busy_next", 64'(busy_after_abort), 64'd0);
        chk("abort_trailing_vld", 64'(vld_after_abort), 64'd1);
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_ren_count", 64'(n_ren), 64'd2);
        chk("abort_vld_count", 64'(n_vld), 64'd2);
        chk("abort_wen_count", 64'(n_wen), 64'd0);

        // zero configuration goes straight to DONE
        run(0, 4, 0, 0, 1000);
        chk("kij0_done_cycle", 64'(done_cyc), 64'd1);
        chk("kij0_ren_count", 64'(n_ren), 64'd0);
        chk("kij0_wen_count", 64'(n_wen), 64'd0);
        chk("kij0_clr_count", 64'(n_clr), 64'd0);
        run(5, 0, 0, 0, 1000);
        chk("onij0_done_cycle", 64'(done_cyc), 64'd1);
        chk("onij0_ren_count", 64'(n_ren), 64'd0);

        // abort and start together in IDLE: nothing starts
        cfg_kij = KBW'(2); cfg_onij = ABW'(2);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);
        chk("abort_start_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        chk("abort_start_clr", 64'(acc_clr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
